// File: rtl/divide_remainder_if.sv
// rtl/divide_remainder_if.sv - request/result bundle for the 2W-by-W divider
interface divide_remainder_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  start;
  logic [DATA_WIDTH-1:0] n_hi;
  logic [DATA_WIDTH-1:0] n_lo;
  logic [DATA_WIDTH-1:0] d;
  logic                  ready;
  logic                  done;
  logic [DATA_WIDTH-1:0] q;
  logic [DATA_WIDTH-1:0] r;
  logic                  err;

  // requester side: issues operands and start, observes status and results
  modport master (
    output start, n_hi, n_lo, d,
    input  ready, done, q, r, err
  );

  // divider side
  modport slave (
    input  start, n_hi, n_lo, d,
    output ready, done, q, r, err
  );
endinterface

// File: rtl/divide_remainder.sv
// rtl/divide_remainder.sv - sequential restoring divider, {n_hi,n_lo} / d -> q, r
module divide_remainder #(
  parameter int DATA_WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  divide_remainder_if.slave  bus
);

  localparam int                CW   = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0]     LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [DATA_WIDTH:0]   rem;     // partial remainder, one guard bit wide
  logic [DATA_WIDTH-1:0] quo;     // dividend low word shifting out, quotient bits shifting in
  logic [DATA_WIDTH-1:0] div;     // divisor captured at acceptance
  logic [CW-1:0]         cnt;     // iteration counter

  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH:0]   diff;
  logic                  ge;
  logic [DATA_WIDTH:0]   rem_next;
  logic [DATA_WIDTH-1:0] quo_next;
  logic                  bad_req;

  assign bus.ready = (state == IDLE);

  // Division by zero, or n_hi >= d, would need a quotient wider than one word.
  assign bad_req = (bus.d == '0) || (bus.n_hi >= bus.d);

  // One restoring step: shift {rem,quo} left, subtract the divisor when it fits.
  // A set guard bit means the shifted value exceeds any divisor, so it forces a subtract.
  always_comb begin
    shifted  = {rem[DATA_WIDTH-1:0], quo[DATA_WIDTH-1]};
    diff     = shifted - {1'b0, div};
    ge       = rem[DATA_WIDTH] | (shifted >= {1'b0, div});
    rem_next = ge ? diff : shifted;
    quo_next = {quo[DATA_WIDTH-2:0], ge};
  end

  // Control FSM with registered results and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rem      <= '0;
      quo      <= '0;
      div      <= '0;
      cnt      <= '0;
      bus.done <= 1'b0;
      bus.q    <= '0;
      bus.r    <= '0;
      bus.err  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bad_req) begin
              bus.err <= 1'b1;
              bus.q   <= '0;
              bus.r   <= '0;
              state   <= DONE;
            end else begin
              bus.err <= 1'b0;
              rem     <= {1'b0, bus.n_hi};
              quo     <= bus.n_lo;
              div     <= bus.d;
              cnt     <= '0;
              state   <= RUN;
            end
          end
        end
        RUN: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            bus.q   <= quo_next;
            bus.r   <= rem_next[DATA_WIDTH-1:0];
            // The remainder always fits one word once n_hi < d; a set top bit
            // here could only come from a quotient overflow.
            bus.err <= rem_next[DATA_WIDTH];
            state   <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divide_remainder.sv
// tb/tb_divide_remainder.sv - directed and randomized checks for divide_remainder
module tb_divide_remainder;

  localparam int W = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  divide_remainder_if #(.DATA_WIDTH(W)) bus ();

  divide_remainder #(.DATA_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request; lat = negedge index (0 = cycle after edge 0) where done was seen,
  // busy = cycles with ready low before done. With toggle set, start stays high and
  // operands are scrambled every cycle until done shows up.
  task automatic do_req(input logic [W-1:0] hi, input logic [W-1:0] lo, input logic [W-1:0] dv,
                        input bit toggle, output int lat, output int busy);
    @(negedge clk);
    bus.start = 1'b1;
    bus.n_hi  = hi;
    bus.n_lo  = lo;
    bus.d     = dv;
    @(posedge clk);
    #1;
    if (!toggle) bus.start = 1'b0;
    lat  = -1;
    busy = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!bus.ready) busy++;
      if (bus.done) begin
        lat = k;
        break;
      end
      if (toggle) begin
        bus.n_hi = {$urandom, $urandom};
        bus.n_lo = {$urandom, $urandom};
        bus.d    = {$urandom, $urandom};
      end
    end
    bus.start = 1'b0;
  endtask

  initial begin
    int lat;
    int busy;
    int extra_done;
    logic [W-1:0] hi, lo, dv;

    bus.start = 1'b0;
    bus.n_hi  = '0;
    bus.n_lo  = '0;
    bus.d     = '0;

    // reset state
    #3;
    check("rst_ready", bus.ready, 1);
    check("rst_done",  bus.done,  0);
    check("rst_q",     bus.q,     0);
    check("rst_r",     bus.r,     0);
    check("rst_err",   bus.err,   0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 100 / 7
    do_req(64'd0, 64'd100, 64'd7, 1'b0, lat, busy);
    check("small_lat",  lat,     65);
    check("small_busy", busy,    65);
    check("small_q",    bus.q,   14);
    check("small_r",    bus.r,   2);
    check("small_err",  bus.err, 0);
    @(negedge clk);
    check("small_done_pulse", bus.done, 0);
    check("small_q_hold",     bus.q,    14);

    // largest valid operands
    do_req(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, lat, busy);
    check("max_q",   bus.q,   64'hFFFF_FFFF_FFFF_FFFF);
    check("max_r",   bus.r,   64'hFFFF_FFFF_FFFF_FFFE);
    check("max_err", bus.err, 0);

    // 2^64 / 2
    do_req(64'd1, 64'd0, 64'd2, 1'b0, lat, busy);
    check("pow_q", bus.q, 64'h8000_0000_0000_0000);
    check("pow_r", bus.r, 0);

    // (3*2^64 + 5) / 16
    do_req(64'd3, 64'd5, 64'h10, 1'b0, lat, busy);
    check("mix_q", bus.q, 64'h3000_0000_0000_0000);
    check("mix_r", bus.r, 5);

    // divide by zero
    do_req(64'd123, 64'd456, 64'd0, 1'b0, lat, busy);
    check("dz_lat",  lat,     1);
    check("dz_err",  bus.err, 1);
    check("dz_q",    bus.q,   0);
    check("dz_r",    bus.r,   0);

    // valid request clears err
    do_req(64'd0, 64'd50, 64'd5, 1'b0, lat, busy);
    check("clr_err", bus.err, 0);
    check("clr_q",   bus.q,   10);

    // quotient overflow: n_hi == d
    do_req(64'd5, 64'd0, 64'd5, 1'b0, lat, busy);
    check("ovf_lat",  lat,     1);
    check("ovf_busy", busy,    1);
    check("ovf_err",  bus.err, 1);
    check("ovf_q",    bus.q,   0);
    check("ovf_r",    bus.r,   0);

    // start held and operands scrambled during RUN
    do_req(64'd0, 64'd1000, 64'd9, 1'b1, lat, busy);
    check("hold_lat", lat,     65);
    check("hold_q",   bus.q,   111);
    check("hold_r",   bus.r,   1);
    check("hold_err", bus.err, 0);
    extra_done = 0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (bus.done) extra_done++;
    end
    check("hold_single_done", extra_done, 0);
    check("hold_q_stable",    bus.q,      111);

    // reset mid-run, after a nonzero result is being held
    do_req(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, lat, busy);
    @(negedge clk);
    bus.start = 1'b1;
    bus.n_hi  = 64'd0;
    bus.n_lo  = 64'd100;
    bus.d     = 64'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_busy", bus.ready, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", bus.ready, 1);
    check("mid_rst_q",     bus.q,     0);
    check("mid_rst_r",     bus.r,     0);
    check("mid_rst_err",   bus.err,   0);
    check("mid_rst_done",  bus.done,  0);
    @(negedge clk);
    rst_n = 1'b1;
    extra_done = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (bus.done) extra_done++;
    end
    check("mid_no_done", extra_done, 0);
    do_req(64'd0, 64'd9, 64'd3, 1'b0, lat, busy);
    check("post_rst_lat", lat,   65);
    check("post_rst_q",   bus.q, 3);
    check("post_rst_r",   bus.r, 0);

    // randomized requests against a multiply-add reference
    for (int i = 0; i < 1000; i++) begin
      if (i % 4 == 0) dv = 64'($urandom_range(1, 1000));
      else            dv = {$urandom, $urandom};
      if (dv == 0) dv = 64'd1;
      hi = {$urandom, $urandom} % dv;
      lo = {$urandom, $urandom};
      do_req(hi, lo, dv, 1'b0, lat, busy);
      check("rnd_lat", lat, 65);
      check("rnd_muladd", ({64'd0, bus.q} * {64'd0, dv}) + {64'd0, bus.r}, {hi, lo});
      check("rnd_r_lt_d", bus.r < dv, 1);
      check("rnd_err", bus.err, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/divide_remainder.md
DIVIDE_REMAINDER -- requirements
Module: divide_remainder

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set the width of each operand word; all widths below follow it.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 start  input  1  SHALL request a division; sampled only while ready=1.
REQ-005 n_hi  input  DATA_WIDTH  SHALL be the dividend upper word.
REQ-006 n_lo  input  DATA_WIDTH  SHALL be the dividend lower word.
REQ-007 d  input  DATA_WIDTH  SHALL be the divisor.
REQ-008 ready  output  1  SHALL be high when the block is idle and can accept start.
REQ-009 done  output  1  SHALL be a one-cycle pulse marking valid q, r, err.
REQ-010 q  output  DATA_WIDTH  SHALL be the quotient.
REQ-011 r  output  DATA_WIDTH  SHALL be the remainder.
REQ-012 err  output  1  SHALL flag an invalid request (d=0 or quotient overflow).

Function
REQ-013 The block SHALL compute q, r such that {n_hi,n_lo} = q*d + r with r < d: the inverse of the multiply-add x*y+z+cin.
REQ-014 The block SHALL be an FSM with states IDLE, RUN and DONE; ready = (state==IDLE).
REQ-015 In IDLE with start=1 and d!=0 and n_hi<d, the block SHALL latch n_hi into a DATA_WIDTH+1 bit partial remainder, n_lo into the quotient shift register and d into a divisor register, clear the iteration counter, and go to RUN.
REQ-016 In IDLE with start=1 and (d==0 or n_hi>=d), the block SHALL set err=1, q=0, r=0 and go directly to DONE.
REQ-017 Each RUN cycle SHALL shift {remainder,quotient} left one bit; if shifted remainder >= divisor, subtract divisor and set the quotient LSB to 1, else set it to 0 (restoring division).
REQ-018 RUN SHALL last exactly DATA_WIDTH cycles, counted by a counter of ceil(log2(DATA_WIDTH))+1 bits; after the last iteration the block SHALL load q and r (low DATA_WIDTH bits of the remainder) and go to DONE.
REQ-019 In DONE, done SHALL be 1 for exactly that one cycle, then the FSM SHALL return to IDLE.
REQ-020 Latency: with start sampled at edge 0, done SHALL be high in the cycle after edge DATA_WIDTH+1 (65 cycles for 64); for an error request, in the cycle after edge 1.
REQ-021 q, r and err SHALL hold their values from DONE until the next accepted start, which SHALL clear err.
REQ-022 start while in RUN or DONE SHALL be ignored with no effect on the operation in progress.
REQ-023 Inputs n_hi, n_lo and d SHALL be used only in the start-accepting cycle; later changes SHALL not affect the result.
REQ-024 The comparison and subtraction SHALL use DATA_WIDTH+1 bits so the bit shifted out of the remainder is kept.

Reset
REQ-025 rst_n=0 SHALL immediately, and without a clock, force state=IDLE, ready=1, done=0, err=0, q=0, r=0, and clear the counter and internal registers.
REQ-026 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse; the first start after release SHALL run normally.

Verification
REQ-027 n_hi=0, n_lo=100, d=7, start pulse -> done 65 cycles later with q=14, r=2, err=0; ready low for exactly those cycles.
REQ-028 n_hi=0xFFFFFFFFFFFFFFFE, n_lo=0xFFFFFFFFFFFFFFFF, d=0xFFFFFFFFFFFFFFFF -> q=0xFFFFFFFFFFFFFFFF, r=0xFFFFFFFFFFFFFFFE, err=0.
REQ-029 d=0 (any dividend), and separately n_hi=5, d=5 -> done in the cycle after edge 1, err=1, q=0, r=0; next valid request clears err.
REQ-030 Start held high and operand inputs toggled during RUN -> single result matching the operands captured at acceptance; one done pulse.
REQ-031 rst_n pulsed low mid-RUN -> outputs zero at once, no done; then n_hi=0, n_lo=9, d=3 -> q=3, r=0.
REQ-032 Randomized: 1000 requests with n_hi<d, d!=0 -> q*d+r equals {n_hi,n_lo}, r<d, via a multiply-add reference model.
